md_seq_ctrl: RTL and testbench

- Sequencing controller for the pipeline's multiply/divide unit (HI/LO datapath).
- Sits between the E stage and the MD datapath.
  - Decides when an E-stage MD op is issued, gated by flush and occupancy.
  - Models the multi-cycle occupancy of mult/div.
  - Produces the D-stage stall for any MD-related instruction (mult/div/mfhi/mflo/mthi/mtlo) while the unit is starting or busy.
- Replaces ad-hoc counters in the datapath with an explicit FSM and a sticky protocol-error flag for verification.

---
 rtl/md_seq_ctrl.sv | 113 +++++++++++
 tb/tb_md_seq_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/md_seq_ctrl.sv
// md_seq_ctrl: issue/occupancy sequencer for the multiply/divide (HI/LO) unit.
// Decides when an E-stage MD op reaches the datapath, tracks how long a
// mult/div keeps the unit occupied, stalls D-stage MD instructions meanwhile,
// and keeps a sticky flag for ops that arrive when they cannot be accepted.
//
//   state | meaning
//   IDLE  | unit free; an unflushed op 1..6 issues this cycle
//   MBUSY | mult/multu in flight; cnt counts remaining busy cycles
//   DBUSY | div/divu in flight; cnt counts remaining busy cycles

module md_seq_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CW       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] e_md_op,
  input  logic       flush_e,
  input  logic       d_md_use,
  output logic [2:0] md_op_out,
  output logic       md_start,
  output logic       md_busy,
  output logic       md_done,
  output logic       stall_d,
  output logic       ovr_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MBUSY = 2'd1,
    DBUSY = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovr_err_q, ovr_err_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic op_valid;
  logic op_present;
  logic issue;

  // Issue decision, next-state/counter computation and error detection.
  always_comb begin
    op_valid   = (e_md_op >= 3'd1) && (e_md_op <= 3'd6);
    op_present = (e_md_op != 3'd0) && !flush_e;
    issue      = (state_q == IDLE) && !flush_e && op_valid;

    md_op_out  = issue ? e_md_op : 3'd0;
    md_start   = issue && (e_md_op <= 3'd4);

    state_d    = state_q;
    cnt_d      = cnt_q;
    ovr_err_d  = ovr_err_q;

    case (state_q)
      IDLE: begin
        if (issue && (e_md_op <= 3'd2)) begin
          state_d = MBUSY;
          cnt_d   = CW'(MULT_LAT);
        end else if (issue && (e_md_op <= 3'd4)) begin
          state_d = DBUSY;
          cnt_d   = CW'(DIV_LAT);
        end
        // op 7 is reserved: never issued, but flagged when it is live
        if (op_present && (e_md_op == 3'd7)) ovr_err_d = 1'b1;
      end
      MBUSY, DBUSY: begin
        // flush_e cannot cancel: HI/LO were committed at issue
        if (cnt_q <= CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - CW'(1);
        end
        if (op_present) ovr_err_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // busy/done are registered so they carry no path from the inputs
    busy_d = (state_d != IDLE);
    done_d = (state_d != IDLE) && (cnt_d == CW'(1));
  end

  // State, counter, sticky error and registered status flags; reset wins over all.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ovr_err_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ovr_err_q <= ovr_err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign md_busy = busy_q;
  assign md_done = done_q;
  assign ovr_err = ovr_err_q;
  assign stall_d = d_md_use && (md_start || busy_q);

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Bench for md_seq_ctrl: directed scenarios followed by random traffic, all
// checked each cycle against a timeline model (busy window as a range of
// cycle numbers, sticky error as a flag).

module tb_md_seq_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] e_md_op;
  logic       flush_e;
  logic       d_md_use;
  logic [2:0] md_op_out;
  logic       md_start, md_busy, md_done, stall_d, ovr_err;

  md_seq_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CW(4)) dut (
    .clk(clk), .reset(reset), .e_md_op(e_md_op), .flush_e(flush_e),
    .d_md_use(d_md_use), .md_op_out(md_op_out), .md_start(md_start),
    .md_busy(md_busy), .md_done(md_done), .stall_d(stall_d), .ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: the unit is busy on every cycle number in (issue, busy_end].
  int cyc      = 0;
  int busy_end = -1;
  bit err_m    = 1'b0;
  bit chk_en   = 1'b0;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare mid-cycle, advance model past the edge.
  task automatic step(input logic [2:0] op, input bit fl, input bit d, input bit rst_n);
    bit busy, done, issue, start, stall;
    logic [2:0] exp_op;
    e_md_op  = op;
    flush_e  = fl;
    d_md_use = d;
    reset    = rst_n;
    busy  = (cyc <= busy_end);
    done  = (cyc == busy_end);
    issue = !busy && !fl && (op >= 1) && (op <= 6);
    exp_op = issue ? op : 3'd0;
    start = issue && (op <= 4);
    stall = d && (start || busy);
    @(negedge clk);
    if (chk_en) begin
      check("md_op_out", md_op_out, exp_op);
      check("md_start",  {2'b0, md_start}, {2'b0, start});
      check("md_busy",   {2'b0, md_busy},  {2'b0, busy});
      check("md_done",   {2'b0, md_done},  {2'b0, done});
      check("stall_d",   {2'b0, stall_d},  {2'b0, stall});
      check("ovr_err",   {2'b0, ovr_err},  {2'b0, err_m});
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      busy_end = cyc;
      err_m    = 1'b0;
    end else if (busy) begin
      if (op != 0 && !fl) err_m = 1'b1;
    end else begin
      if (issue && op <= 2)      busy_end = cyc + MULT_LAT;
      else if (issue && op <= 4) busy_end = cyc + DIV_LAT;
      if (op == 7 && !fl) err_m = 1'b1;
    end
    cyc++;
  endtask

  initial begin
    e_md_op = 3'd0; flush_e = 1'b0; d_md_use = 1'b0; reset = 1'b0;
    // first edge establishes state; checked from the second reset cycle on
    step(3'd0, 0, 0, 0);
    chk_en = 1'b1;
    step(3'd0, 0, 0, 0);

    // mult with D-stage MD use held: start on cycle 0, busy 1..5, done on 5
    step(3'd1, 0, 1, 1);
    for (int i = 0; i < 6; i++) step(3'd0, 0, 1, 1);

    // div runs 10 busy cycles, divu issues on the first free cycle
    step(3'd3, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(3'd0, 0, 1, 1);
    step(3'd4, 0, 1, 1);
    for (int i = 0; i < 10; i++) step(3'd0, 0, 0, 1);

    // mthi/mtlo are single-cycle, never stall
    step(3'd5, 0, 1, 1);
    step(3'd6, 0, 1, 1);
    step(3'd0, 0, 1, 1);

    // flushed multu does nothing; reserved op sets sticky error
    step(3'd2, 1, 1, 1);
    step(3'd0, 0, 1, 1);
    step(3'd7, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(3'd0, 0, 0, 1);
    step(3'd0, 0, 0, 0);

    // op presented on busy cycle 4 of a div: rejected, error, done unchanged
    step(3'd3, 0, 0, 1);
    for (int i = 1; i <= 11; i++) step((i == 4) ? 3'd1 : 3'd0, 0, 1, 1);
    step(3'd0, 0, 0, 0);

    // reset during busy cycle 3 abandons the div; mult issues right after
    step(3'd3, 0, 0, 1);
    step(3'd0, 0, 0, 1);
    step(3'd0, 0, 0, 1);
    step(3'd7, 0, 1, 0);
    step(3'd1, 0, 1, 1);
    for (int i = 0; i < 7; i++) step(3'd0, 1, 1, 1);

    // random traffic: mostly idle slots, some flushes, rare resets
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      step(op, ($urandom_range(0, 3) == 0), 1'($urandom), ($urandom_range(0, 60) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
